// File: rtl/cmd_assembler_pkg.sv
// cmd_assembler_pkg
//   Shared constants for the SUMP command assembler: command-length bit,
//   long-command data length, well-known opcodes and the FSM state encoding.
package cmd_assembler_pkg;

  localparam int CMD_LONG_BIT   = 7;
  localparam int CMD_DATA_BYTES = 4;

  localparam logic [7:0] OP_RESET     = 8'h00;
  localparam logic [7:0] OP_ARM       = 8'h01;
  localparam logic [7:0] OP_QUERY_ID  = 8'h02;
  localparam logic [7:0] OP_SET_FLAGS = 8'h82;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } cmd_state_e;

endpackage

// File: rtl/cmd_timeout_ctr.sv
// cmd_timeout_ctr
//   Idle counter for a partially received long command. Counts cycles while
//   run is high and no byte arrives; expire flags the cycle on which the
//   count has reached TIMEOUT_CYCLES-1 with still no byte present.
// Ports:
//   clock   in   system clock
//   reset   in   asynchronous active-high reset
//   run     in   high while the assembler is collecting data bytes
//   clear   in   a byte arrived this cycle; restart the idle count
//   expire  out  idle limit reached this cycle (combinational)
module cmd_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] idle_cnt;

  // A byte on the expiry cycle clears the count, so the byte wins.
  assign expire = run && !clear && (idle_cnt == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (!run || clear || expire) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cmd_assembler.sv
// cmd_assembler
//   Turns the SUMP byte stream into opcode / config_data / execute for core.
//   Short commands (bit 7 clear) are one byte; long commands (bit 7 set) are
//   followed by four data bytes, least-significant first.
//   Optional: define CMD_TIMEOUT_EN to discard a long command that stalls for
//   TIMEOUT_CYCLES idle cycles (timeout_abort pulses); otherwise DATA waits
//   forever and timeout_abort is tied 0.
// Ports:
//   clock          in   system clock
//   reset          in   asynchronous active-high reset
//   rx_valid       in   one-cycle strobe, rx_data holds a byte
//   rx_data[7:0]   in   received byte
//   opcode[7:0]    out  opcode of last completed command
//   config_data    out  32-bit data of last completed command
//   execute        out  one-cycle pulse, opcode/config_data valid
//   cmd_busy       out  long command partially received
//   timeout_abort  out  one-cycle pulse when a partial command is dropped
//
// state   | meaning
// --------+--------------------------------------------------
// ST_IDLE | waiting for an opcode byte
// ST_DATA | long opcode captured, collecting 4 data bytes
module cmd_assembler
  import cmd_assembler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [7:0]  opcode,
  output logic [31:0] config_data,
  output logic        execute,
  output logic        cmd_busy,
  output logic        timeout_abort
);

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("cmd_assembler: TIMEOUT_CYCLES must be at least 2");
  end

  cmd_state_e  state_q, state_d;
  logic [7:0]  op_q;
  logic [31:0] shift_q;
  logic [1:0]  byte_cnt;

  logic        start_short, start_long, data_byte, last_byte;
  logic        timeout_hit;
  logic        exec_d;
  logic [7:0]  opcode_d;
  logic [31:0] config_d;

  assign start_short = (state_q == ST_IDLE) && rx_valid && !rx_data[CMD_LONG_BIT];
  assign start_long  = (state_q == ST_IDLE) && rx_valid &&  rx_data[CMD_LONG_BIT];
  assign data_byte   = (state_q == ST_DATA) && rx_valid;
  assign last_byte   = data_byte && (byte_cnt == 2'(CMD_DATA_BYTES - 1));

`ifdef CMD_TIMEOUT_EN
  cmd_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .run    (state_q == ST_DATA),
    .clear  (rx_valid),
    .expire (timeout_hit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_abort <= 1'b0;
    end else begin
      timeout_abort <= timeout_hit;
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign timeout_abort = 1'b0;
`endif

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_long) state_d = ST_DATA;
      ST_DATA: if (last_byte || timeout_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // output logic: next values for the registered command interface
  always_comb begin
    exec_d   = 1'b0;
    opcode_d = opcode;
    config_d = config_data;
    if (start_short) begin
      exec_d   = 1'b1;
      opcode_d = rx_data;
      config_d = '0;
    end else if (last_byte) begin
      exec_d   = 1'b1;
      opcode_d = op_q;
      config_d = {rx_data, shift_q[31:8]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opcode      <= '0;
      config_data <= '0;
      execute     <= 1'b0;
      op_q        <= '0;
      shift_q     <= '0;
      byte_cnt    <= '0;
    end else begin
      execute <= exec_d;
      if (exec_d) begin
        opcode      <= opcode_d;
        config_data <= config_d;
      end
      if (start_long) begin
        op_q     <= rx_data;
        byte_cnt <= '0;
      end
      if (data_byte) begin
        shift_q  <= {rx_data, shift_q[31:8]};
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

  assign cmd_busy = (state_q == ST_DATA);

endmodule

// File: tb/tb_cmd_assembler.sv
// tb_cmd_assembler
//   Scoreboard bench for cmd_assembler. Stimulus pushes expected commands
//   (with the cycle execute must appear on); a negedge monitor pops and
//   compares on every execute pulse. Timeout expectations follow whether
//   CMD_TIMEOUT_EN is defined; TIMEOUT_CYCLES is 16.
module tb_cmd_assembler;
  import cmd_assembler_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  opcode;
  logic [31:0] config_data;
  logic        execute;
  logic        cmd_busy;
  logic        timeout_abort;

  cmd_assembler #(.TIMEOUT_CYCLES(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .opcode        (opcode),
    .config_data   (config_data),
    .execute       (execute),
    .cmd_busy      (cmd_busy),
    .timeout_abort (timeout_abort)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   last_cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   aborts = 0;
  int   aborts_before;

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    if (timeout_abort === 1'b1) aborts++;
    if (execute === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_execute: got opcode 0x%0h data 0x%0h at cycle %0d, expected none",
                 opcode, config_data, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("exec_opcode", {24'h0, opcode}, {24'h0, e.op});
        chk("exec_data", config_data, e.data);
        chk("exec_cycle", cyc, e.at);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    last_cyc = cyc;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic expect_cmd(input logic [7:0] op, input logic [31:0] data);
    exp_t e;
    e.op   = op;
    e.data = data;
    e.at   = last_cyc + 1;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    chk("rst_opcode", {24'h0, opcode}, 32'h0);
    chk("rst_data", config_data, 32'h0);
    chk("rst_execute", {31'h0, execute}, 32'h0);
    chk("rst_busy", {31'h0, cmd_busy}, 32'h0);
    chk("rst_abort", {31'h0, timeout_abort}, 32'h0);
    reset = 1'b0;
    idle(2);

    // reset mid-command: partial 0x82 command must vanish
    send(OP_SET_FLAGS);
    send(8'h01);
    chk("mid_busy", {31'h0, cmd_busy}, 32'h1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'h0, cmd_busy}, 32'h0);
    chk("midrst_execute", {31'h0, execute}, 32'h0);
    chk("midrst_opcode", {24'h0, opcode}, 32'h0);
    idle(2);
    reset = 1'b0;
    idle(2);
    send(OP_RESET);
    expect_cmd(8'h00, 32'h0);
    idle(3);

    // short command
    send(OP_ARM);
    expect_cmd(8'h01, 32'h0);
    idle(3);
    chk("short_opcode_hold", {24'h0, opcode}, 32'h01);

    // long command, one byte every 3 cycles
    send(8'h82);
    chk("long_busy0", {31'h0, cmd_busy}, 32'h1);
    idle(2);
    send(8'h78);
    idle(2);
    send(8'h56);
    idle(2);
    send(8'h34);
    chk("long_busy3", {31'h0, cmd_busy}, 32'h1);
    idle(2);
    send(8'h12);
    expect_cmd(8'h82, 32'h12345678);
    chk("long_busy_end", {31'h0, cmd_busy}, 32'h0);
    idle(3);
    chk("long_data_hold", config_data, 32'h12345678);

    // back-to-back bytes every cycle
    send(8'h00);
    expect_cmd(8'h00, 32'h0);
    send(8'hC0);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    send(8'hDD);
    expect_cmd(8'hC0, 32'hDDCCBBAA);
    send(OP_QUERY_ID);
    expect_cmd(8'h02, 32'h0);
    idle(4);

    // stalled long command
    aborts_before = aborts;
    send(8'h81);
    send(8'h11);
    idle(20);
`ifdef CMD_TIMEOUT_EN
    chk("timeout_abort_count", aborts - aborts_before, 1);
    chk("timeout_busy", {31'h0, cmd_busy}, 32'h0);
`else
    chk("no_timeout_abort", aborts - aborts_before, 0);
    chk("no_timeout_busy", {31'h0, cmd_busy}, 32'h1);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    expect_cmd(8'h81, 32'h44332211);
    idle(2);
`endif
    send(OP_ARM);
    expect_cmd(8'h01, 32'h0);
    idle(3);

    // next byte lands exactly on the expiry cycle each time
    aborts_before = aborts;
    send(8'h82);
    send(8'hA1);
    idle(15);
    send(8'hB2);
    idle(15);
    send(8'hC3);
    idle(15);
    send(8'hD4);
    expect_cmd(8'h82, 32'hD4C3B2A1);
    idle(4);
    chk("boundary_no_abort", aborts - aborts_before, 0);

    idle(3);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_assembler.md
# cmd_assembler

- Assembles the SUMP command byte stream from the serial/SPI byte receiver into the `opcode` / `config_data` / `execute` interface consumed by `core`.
- Short commands (opcode 0x00–0x7F) are single bytes. Long commands (opcode 0x80–0xFF) carry four data bytes, least-significant byte first.
- When `CMD_TIMEOUT_EN` is defined, a stalled long command is discarded after an idle timeout so the host can resynchronise.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 1000000: idle `clock` cycles allowed between bytes of a long command before it is discarded. Minimum 2.

Ports:
- clock  in  1  system clock; the single clock of the block.
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe; `rx_data` holds a received byte.
- rx_data  in  8  received byte.
- opcode  out  8  opcode of the last completed command.
- config_data  out  32  data of the last completed command.
- execute  out  1  one-cycle pulse; `opcode` and `config_data` are valid while it is high.
- cmd_busy  out  1  high while a long command is partially received.
- timeout_abort  out  1  one-cycle pulse when a partial command is discarded. Tied 0 without `CMD_TIMEOUT_EN`.

## Operation
- FSM states: IDLE, DATA.
- Internal registers:
  - `op_q`: 8-bit captured opcode.
  - `shift_q`: 32-bit data assembly register.
  - `byte_cnt`: 2-bit count of data bytes received.
  - `idle_cnt`: timeout counter, width $clog2(TIMEOUT_CYCLES).
- IDLE, `rx_valid` with `rx_data[7]`=0 (short command):
  - next cycle: `opcode`=`rx_data`, `config_data`=0, `execute`=1.
  - stay in IDLE.
- IDLE, `rx_valid` with `rx_data[7]`=1 (long command):
  - `op_q`←`rx_data`, `byte_cnt`←0, `idle_cnt`←0.
  - go to DATA.
- DATA, `rx_valid`:
  - `shift_q`←{`rx_data`, `shift_q[31:8]`}, so the first data byte ends in bits [7:0].
  - `byte_cnt`++, `idle_cnt`←0.
  - on the 4th byte: next cycle `opcode`=`op_q`, `config_data`={`rx_data`, `shift_q[31:8]`}, `execute`=1, and the FSM goes to IDLE.
- `opcode` and `config_data` are only updated on the cycle `execute` rises. They hold their values otherwise.
- `cmd_busy` = (state==DATA), registered.
- Byte values are not interpreted beyond bit 7. Unknown opcodes are passed through to `core`.

## Timing
- Reset values: `opcode`=0x00, `config_data`=0, `execute`=0, `cmd_busy`=0, `timeout_abort`=0. The FSM resets to IDLE and all counters reset to 0.
- Latency from the accepted final byte (opcode byte for short, 4th data byte for long) to `execute`: 1 cycle. All outputs are registered.
- Back-to-back `rx_valid` on every cycle is supported with no dropped bytes.
- A byte arriving in the same cycle `execute` is high is accepted normally as the start of the next command.
- Reset asserted mid-command: the partial command is lost and no `execute` is issued. After release the block is in IDLE.
- `execute` never asserts for two consecutive commands without a byte between them. Maximum `execute` rate is one per accepted byte.

## Configuration
- `CMD_TIMEOUT_EN` defined:
  - In DATA, `idle_cnt` increments on each cycle without `rx_valid`.
  - When `idle_cnt` reaches TIMEOUT_CYCLES-1 without `rx_valid`: the FSM goes to IDLE, `timeout_abort` pulses for 1 cycle, and no `execute` is issued.
  - If `rx_valid` arrives in that same cycle, the byte wins: it is accepted and the timeout does not fire.
  - `idle_cnt` holds 0 in IDLE.
- `CMD_TIMEOUT_EN` undefined:
  - No counter is built, `timeout_abort`=0 constantly, and DATA waits indefinitely.
  - TIMEOUT_CYCLES is ignored.

## Structure
- Shared package holds:
  - the constant `CMD_LONG_BIT`=7;
  - the long-command data length `CMD_DATA_BYTES`=4;
  - opcode constants `OP_RESET`=0x00, `OP_ARM`=0x01, `OP_QUERY_ID`=0x02, `OP_SET_FLAGS`=0x82;
  - the FSM state encoding.
- One natural sub-module, `cmd_timeout_ctr`: the idle counter with clear/expire outputs. It is instantiated only under `CMD_TIMEOUT_EN`.

## Test plan
- Reset mid-command: bytes 0x82, 0x01, then assert `reset` → all outputs 0. After release, byte 0x00 → `execute` pulse with `opcode`=0x00.
- Short command: byte 0x01 → 1 cycle later `execute`=1 for exactly 1 cycle, `opcode`=0x01, `config_data`=0x00000000.
- Long command, one byte every 3 cycles: 0x82, 0x78, 0x56, 0x34, 0x12 → `execute` 1 cycle after the last byte with `opcode`=0x82 and `config_data`=0x12345678. `cmd_busy`=1 from the cycle after 0x82 until `execute`.
- Back-to-back on consecutive cycles: 0x00, 0xC0, 0xAA, 0xBB, 0xCC, 0xDD, 0x02 → three `execute` pulses:
  - 0x00 / 0;
  - 0xC0 / 0xDDCCBBAA;
  - 0x02 / 0.
- Timeout (`CMD_TIMEOUT_EN`, TIMEOUT_CYCLES=16): send 0x81, 0x11, then idle 20 cycles → `timeout_abort` pulses once with no `execute`. Then 0x01 → `execute` with `opcode`=0x01.
- Timeout boundary (TIMEOUT_CYCLES=16): deliver the next byte exactly on the expiry cycle → no `timeout_abort`. Completing the command gives `execute` with the correct `config_data`.
